// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared opcodes, bus-source codes and sequencer states for the simple processor
package proc_pkg;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_LD   = 3'b100;
    localparam logic [2:0] OP_ST   = 3'b101;
    localparam logic [2:0] OP_MVNZ = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    // Bus-source codes; must match the one-hot bus-select decoder downstream.
    localparam logic [3:0] SEL_R0   = 4'd0;
    localparam logic [3:0] SEL_R1   = 4'd1;
    localparam logic [3:0] SEL_R2   = 4'd2;
    localparam logic [3:0] SEL_R3   = 4'd3;
    localparam logic [3:0] SEL_R4   = 4'd4;
    localparam logic [3:0] SEL_R5   = 4'd5;
    localparam logic [3:0] SEL_R6   = 4'd6;
    localparam logic [3:0] SEL_R7   = 4'd7;
    localparam logic [3:0] SEL_G    = 4'd8;
    localparam logic [3:0] SEL_A    = 4'd9;
    localparam logic [3:0] SEL_DIN  = 4'd10;
    localparam logic [3:0] SEL_IR   = 4'd11;
    localparam logic [3:0] SEL_PC   = 4'd12;
    localparam logic [3:0] SEL_NONE = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_F0   = 3'd1,
        S_FW   = 3'd2,
        S_F2   = 3'd3,
        S_T1   = 3'd4,
        S_T2   = 3'd5,
        S_TW   = 3'd6,
        S_T3   = 3'd7
    } state_t;

    // Register number to bus-source code (R0-R7 occupy codes 0-7).
    function automatic logic [3:0] sel_reg(input logic [2:0] r);
        return {1'b0, r};
    endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// rtl/reg_select_decoder.sv - 3-to-8 one-hot register load decoder with enable
module reg_select_decoder (
    input  logic       en_i,
    input  logic [2:0] idx_i,
    output logic [7:0] onehot_o
);

    // One-hot load enable for the selected register, all-zero when disabled.
    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o = 8'd1 << idx_i;
        end
    end

endmodule

// File: rtl/controller_fsm.sv
// rtl/controller_fsm.sv - instruction fetch/execute sequencer driving bus select and load strobes
module controller_fsm #(
    parameter int MEM_WAIT = 1
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Run,
    input  logic [8:0] IR,
    input  logic       GNZ,
    output logic [3:0] Sel,
    output logic [7:0] RIn,
    output logic       AIn,
    output logic       GIn,
    output logic       IRIn,
    output logic       AddrIn,
    output logic       DoutIn,
    output logic       PCIncr,
    output logic       W_D,
    output logic       AddSub,
    output logic       Done
);
    import proc_pkg::*;

    // Wait-counter preloads: FW lasts MEM_WAIT cycles, TW lasts MEM_WAIT-1 cycles.
    localparam logic [1:0] FW_INIT = 2'((MEM_WAIT > 0) ? MEM_WAIT - 1 : 0);
    localparam logic [1:0] TW_INIT = 2'((MEM_WAIT > 1) ? MEM_WAIT - 2 : 0);

    state_t     state_q, state_d;
    logic [1:0] wcnt_q, wcnt_d;
    logic       rin_en;
    logic [2:0] op, rx, ry;

    assign op = IR[8:6];
    assign rx = IR[5:3];
    assign ry = IR[2:0];

    // Only X is ever a destination, so the decoder is always fed from X.
    reg_select_decoder u_rin_dec (
        .en_i     (rin_en),
        .idx_i    (rx),
        .onehot_o (RIn)
    );

    // State and wait-counter registers; reset abandons any partial instruction.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Next-state and per-cycle strobe decode from state and instruction.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        Sel     = SEL_NONE;
        rin_en  = 1'b0;
        AIn     = 1'b0;
        GIn     = 1'b0;
        IRIn    = 1'b0;
        AddrIn  = 1'b0;
        DoutIn  = 1'b0;
        PCIncr  = 1'b0;
        W_D     = 1'b0;
        AddSub  = 1'b0;
        Done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Run) begin
                    state_d = S_F0;
                end
            end
            S_F0: begin
                Sel    = SEL_PC;
                AddrIn = 1'b1;
                PCIncr = 1'b1;
                if (MEM_WAIT > 0) begin
                    state_d = S_FW;
                    wcnt_d  = FW_INIT;
                end else begin
                    state_d = S_F2;
                end
            end
            S_FW: begin
                if (wcnt_q == 2'd0) begin
                    state_d = S_F2;
                end else begin
                    wcnt_d = wcnt_q - 2'd1;
                end
            end
            S_F2: begin
                Sel     = SEL_DIN;
                IRIn    = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                case (op)
                    OP_MV: begin
                        Sel    = sel_reg(ry);
                        rin_en = 1'b1;
                        Done   = 1'b1;
                    end
                    OP_MVI: begin
                        Sel     = SEL_PC;
                        AddrIn  = 1'b1;
                        PCIncr  = 1'b1;
                        state_d = S_T2;
                    end
                    OP_ADD, OP_SUB: begin
                        Sel     = sel_reg(rx);
                        AIn     = 1'b1;
                        state_d = S_T2;
                    end
                    OP_LD, OP_ST: begin
                        Sel     = sel_reg(ry);
                        AddrIn  = 1'b1;
                        state_d = S_T2;
                    end
                    OP_MVNZ: begin
                        if (GNZ) begin
                            Sel    = sel_reg(ry);
                            rin_en = 1'b1;
                        end
                        Done = 1'b1;
                    end
                    default: begin
                        Done = 1'b1;
                    end
                endcase
            end
            S_T2: begin
                case (op)
                    OP_ADD, OP_SUB: begin
                        Sel     = sel_reg(ry);
                        GIn     = 1'b1;
                        AddSub  = IR[6];
                        state_d = S_T3;
                    end
                    OP_ST: begin
                        Sel    = sel_reg(rx);
                        DoutIn = 1'b1;
                        W_D    = 1'b1;
                        Done   = 1'b1;
                    end
                    OP_MVI, OP_LD: begin
                        if (MEM_WAIT > 1) begin
                            state_d = S_TW;
                            wcnt_d  = TW_INIT;
                        end else begin
                            state_d = S_T3;
                        end
                    end
                    default: begin
                        state_d = S_IDLE;
                    end
                endcase
            end
            S_TW: begin
                if (wcnt_q == 2'd0) begin
                    state_d = S_T3;
                end else begin
                    wcnt_d = wcnt_q - 2'd1;
                end
            end
            S_T3: begin
                case (op)
                    OP_MVI, OP_LD: begin
                        Sel    = SEL_DIN;
                        rin_en = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        Sel    = SEL_G;
                        rin_en = 1'b1;
                    end
                    default: begin
                    end
                endcase
                Done = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Run is only looked at here and in IDLE, so a dropped Run finishes the instruction.
        if (Done) begin
            state_d = Run ? S_F0 : S_IDLE;
        end
    end

endmodule

// File: tb/tb_controller_fsm.sv
// tb/tb_controller_fsm.sv - self-checking bench for controller_fsm across MEM_WAIT 0..3
module tb_controller_fsm;

    localparam int NDUT = 4;

    localparam logic [8:0] F_AIN  = 9'h100;
    localparam logic [8:0] F_GIN  = 9'h080;
    localparam logic [8:0] F_IRIN = 9'h040;
    localparam logic [8:0] F_ADDR = 9'h020;
    localparam logic [8:0] F_DOUT = 9'h010;
    localparam logic [8:0] F_PCI  = 9'h008;
    localparam logic [8:0] F_WD   = 9'h004;
    localparam logic [8:0] F_SUB  = 9'h002;
    localparam logic [8:0] F_DONE = 9'h001;
    localparam logic [20:0] IDLE_REC = {4'd15, 8'd0, 9'd0};

    logic clk;
    logic resetn;
    logic go;
    logic chk_en;

    logic [3:0] sel_w    [NDUT];
    logic [7:0] rin_w    [NDUT];
    logic       ain_w    [NDUT];
    logic       gin_w    [NDUT];
    logic       irin_w   [NDUT];
    logic       addr_w   [NDUT];
    logic       dout_w   [NDUT];
    logic       pci_w    [NDUT];
    logic       wd_w     [NDUT];
    logic       addsub_w [NDUT];
    logic       done_w   [NDUT];

    logic [8:0] prog_ir  [0:15];
    logic       prog_gnz [0:15];
    int         prog_n;

    logic [20:0] trace [NDUT][0:255];
    int tlen  [NDUT];
    int tpos  [NDUT] = '{default: 0};
    int ndone [NDUT] = '{default: 0};

    int vectors = 0;
    int misc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        logic [8:0] ir_q;
        logic       gnz_q;
        int         ptr_q;
        logic       run_g;

        assign run_g = go && (ptr_q < prog_n);

        // Instruction register of the surrounding datapath: loads the next program word on IRIn.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                ir_q  <= '0;
                gnz_q <= 1'b0;
                ptr_q <= 0;
            end else if (irin_w[g] && ptr_q < 16) begin
                ir_q  <= prog_ir[ptr_q];
                gnz_q <= prog_gnz[ptr_q];
                ptr_q <= ptr_q + 1;
            end
        end

        controller_fsm #(.MEM_WAIT(g)) u_dut (
            .Clock  (clk),
            .Resetn (resetn),
            .Run    (run_g),
            .IR     (ir_q),
            .GNZ    (gnz_q),
            .Sel    (sel_w[g]),
            .RIn    (rin_w[g]),
            .AIn    (ain_w[g]),
            .GIn    (gin_w[g]),
            .IRIn   (irin_w[g]),
            .AddrIn (addr_w[g]),
            .DoutIn (dout_w[g]),
            .PCIncr (pci_w[g]),
            .W_D    (wd_w[g]),
            .AddSub (addsub_w[g]),
            .Done   (done_w[g])
        );
    end

    function automatic logic [20:0] rec(input logic [3:0] s, input logic [7:0] r, input logic [8:0] f);
        return {s, r, f};
    endfunction

    function automatic logic [7:0] bit8(input logic [2:0] x);
        logic [7:0] v;
        v = 8'd1 << x;
        return v;
    endfunction

    function automatic logic [20:0] obs(input int k);
        return {sel_w[k], rin_w[k], ain_w[k], gin_w[k], irin_w[k], addr_w[k],
                dout_w[k], pci_w[k], wd_w[k], addsub_w[k], done_w[k]};
    endfunction

    task automatic chk(input string name, input int k, input logic [20:0] got, input logic [20:0] want);
        vectors++;
        if (got !== want) begin
            misc++;
            $display("FAIL %s dut W=%0d: got %h required %h", name, k, got, want);
        end
    endtask

    task automatic push(input int k, input logic [20:0] r);
        trace[k][tlen[k]] = r;
        tlen[k]++;
    endtask

    // Expected per-cycle outputs of the whole program for memory wait w.
    task automatic build_trace(input int k, input int w);
        logic [2:0] op, x, y;
        tlen[k] = 0;
        repeat (4) push(k, IDLE_REC);
        for (int i = 0; i < prog_n; i++) begin
            op = prog_ir[i][8:6];
            x  = prog_ir[i][5:3];
            y  = prog_ir[i][2:0];
            push(k, rec(4'd12, 8'd0, F_ADDR | F_PCI));
            for (int j = 0; j < w; j++) push(k, IDLE_REC);
            push(k, rec(4'd10, 8'd0, F_IRIN));
            case (op)
                3'd0: push(k, rec({1'b0, y}, bit8(x), F_DONE));
                3'd1, 3'd4: begin
                    if (op == 3'd1) push(k, rec(4'd12, 8'd0, F_ADDR | F_PCI));
                    else            push(k, rec({1'b0, y}, 8'd0, F_ADDR));
                    push(k, IDLE_REC);
                    for (int j = 0; j < w - 1; j++) push(k, IDLE_REC);
                    push(k, rec(4'd10, bit8(x), F_DONE));
                end
                3'd2, 3'd3: begin
                    push(k, rec({1'b0, x}, 8'd0, F_AIN));
                    push(k, rec({1'b0, y}, 8'd0, F_GIN | ((op == 3'd3) ? F_SUB : 9'd0)));
                    push(k, rec(4'd8, bit8(x), F_DONE));
                end
                3'd5: begin
                    push(k, rec({1'b0, y}, 8'd0, F_ADDR));
                    push(k, rec({1'b0, x}, 8'd0, F_DOUT | F_WD | F_DONE));
                end
                3'd6: begin
                    if (prog_gnz[i]) push(k, rec({1'b0, y}, bit8(x), F_DONE));
                    else             push(k, rec(4'd15, 8'd0, F_DONE));
                end
                default: push(k, rec(4'd15, 8'd0, F_DONE));
            endcase
        end
    endtask

    // Single compare process: every cycle each DUT against its model trace, plus literal pins at Done.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < NDUT; k++) begin
                logic [20:0] got, want;
                got  = obs(k);
                want = (tpos[k] < tlen[k]) ? trace[k][tpos[k]] : IDLE_REC;
                chk($sformatf("trace cycle %0d", tpos[k]), k, got, want);
                tpos[k]++;
                if (got[7]) begin
                    chk("AddSub with GIn", k, {20'd0, got[1]}, {20'd0, ndone[k] == 1});
                end
                if (got[0]) begin
                    ndone[k]++;
                    case (ndone[k])
                        1: chk("mv R3,R5 T1",    k, {9'd0, got[20:9]}, {9'd0, 4'd5,  8'h08});
                        2: chk("sub R2,R1 T3",   k, {9'd0, got[20:9]}, {9'd0, 4'd8,  8'h04});
                        3: chk("mvnz GNZ=0 T1",  k, {9'd0, got[20:9]}, {9'd0, 4'd15, 8'h00});
                        4: chk("mvnz GNZ=1 T1",  k, {9'd0, got[20:9]}, {9'd0, 4'd4,  8'h02});
                        5: chk("mvi R7 T3",      k, {9'd0, got[20:9]}, {9'd0, 4'd10, 8'h80});
                        6: chk("ld R1,R2 T3",    k, {9'd0, got[20:9]}, {9'd0, 4'd10, 8'h02});
                        7: chk("add R0,R7 T3",   k, {9'd0, got[20:9]}, {9'd0, 4'd8,  8'h01});
                        8: chk("illegal T1",     k, {9'd0, got[20:9]}, {9'd0, 4'd15, 8'h00});
                        9: chk("st R6,R0 T2",    k, {15'd0, got[20:17], got[4], got[2]}, {15'd0, 4'd6, 2'b11});
                        default: chk("extra Done", k, {20'd0, got[0]}, 21'd0);
                    endcase
                end
            end
        end
    end

    initial begin
        logic found;
        resetn = 1'b0;
        go     = 1'b0;
        chk_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            prog_ir[i]  = '0;
            prog_gnz[i] = 1'b0;
        end
        prog_ir[0] = 9'b000_011_101;  prog_gnz[0] = 1'b0;
        prog_ir[1] = 9'b011_010_001;  prog_gnz[1] = 1'b0;
        prog_ir[2] = 9'b110_001_100;  prog_gnz[2] = 1'b0;
        prog_ir[3] = 9'b110_001_100;  prog_gnz[3] = 1'b1;
        prog_ir[4] = 9'b001_111_000;  prog_gnz[4] = 1'b0;
        prog_ir[5] = 9'b100_001_010;  prog_gnz[5] = 1'b0;
        prog_ir[6] = 9'b010_000_111;  prog_gnz[6] = 1'b1;
        prog_ir[7] = 9'b111_000_000;  prog_gnz[7] = 1'b0;
        prog_ir[8] = 9'b101_110_000;  prog_gnz[8] = 1'b0;
        prog_n = 9;
        for (int k = 0; k < NDUT; k++) build_trace(k, k);

        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) chk("reset state", k, obs(k), IDLE_REC);
        resetn = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        go = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) chk("Done count", k, 21'(ndone[k]), 21'd9);

        chk_en = 1'b0;
        go     = 1'b0;
        resetn = 1'b0;
        prog_ir[0] = 9'b100_001_010;
        prog_n = 1;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        go     = 1'b1;
        found  = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            @(negedge clk);
            if (addr_w[1] && sel_w[1] == 4'd2) found = 1'b1;
        end
        chk("ld T1 reached", 1, {20'd0, found}, 21'd1);
        @(posedge clk);
        #1;
        chk("ld T2 quiet", 1, obs(1), IDLE_REC);
        resetn = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) chk("async reset clears", k, obs(k), IDLE_REC);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) chk("F0 after reset", k, obs(k), rec(4'd12, 8'd0, F_ADDR | F_PCI));
        repeat (30) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

endmodule
